// File: rtl/adder_seq_pkg.sv
// Shared definitions for the adder operand sequencer: FSM state encoding,
// default build constants and the settle-counter width helper.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH         = 4;
    localparam int DEFAULT_SETTLE_CYCLES = 8;

    // ceil(log2(cycles)) + 1 bits, so the reload value always fits
    function automatic int cnt_width(input int cycles);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < cycles) begin
                w = i + 1;
            end
        end
        return w + 1;
    endfunction

endpackage

// File: rtl/adder_operand_sequencer_settle_counter.sv
// Down-counter that times the adder ripple settle window. Loaded on operand
// acceptance, decremented while ticking, and flags done when it has run out.
module settle_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Reload on acceptance, otherwise count down to zero and stay there
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = tick && (cnt == '0);

endmodule

// File: rtl/adder_operand_sequencer.sv
// Control stage in front of the gate-delayed ripple adder. Registers an
// operand pair, holds it stable for SETTLE_CYCLES clocks, then captures the
// adder outputs and offers them downstream via valid/ready.
// Optional feature macro: STICKY_OVERFLOW_EN (adds ovf_clear / ovf_sticky).
module adder_operand_sequencer
    import adder_seq_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] opA,
    output logic [WIDTH-1:0] opB,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_carryout,
    input  logic             add_overflow,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef STICKY_OVERFLOW_EN
    input  logic             ovf_clear,
    output logic             ovf_sticky,
`endif
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carryout,
    output logic             out_overflow
);

    localparam int               CNT_W    = cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

    state_t state_q;
    state_t state_d;
    logic   accept;
    logic   capture;
    logic   drain;
    logic   settle_done;

    settle_counter #(
        .CNT_W (CNT_W)
    ) u_settle_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (LOAD_VAL),
        .tick       (state_q == SETTLE),
        .done       (settle_done)
    );

    // Ready depends on the state register alone, never on in_valid/out_ready
    assign in_ready = (state_q == IDLE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake strobes
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        drain   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    drain   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand registers feeding the adder; change only on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opA <= '0;
            opB <= '0;
        end else if (accept) begin
            opA <= in_a;
            opB <= in_b;
        end
    end

    // Result capture once the ripple has settled; values persist after drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_sum      <= '0;
            out_carryout <= 1'b0;
            out_overflow <= 1'b0;
        end else if (capture) begin
            out_sum      <= add_sum;
            out_carryout <= add_carryout;
            out_overflow <= add_overflow;
        end
    end

    // Output valid: raised on capture, dropped when downstream takes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STICKY_OVERFLOW_EN
    // Sticky overflow flag; a capture with overflow beats a same-edge clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else if (capture && add_overflow) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clear) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule
